// File: rtl/shift_reg_pkg.sv
// Shared constants for the serial-in, parallel-out shift register family.
// Users of the block refer to these rather than repeating literals.
//   DEFAULT_WIDTH       : default number of stages (4)
//   DEFAULT_RESET_VALUE : default contents loaded on reset (all zeros)
package shift_reg_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_RESET_VALUE = '0;

endpackage : shift_reg_pkg

// File: rtl/shift_reg_4bit_if.sv
// Bundles the data signals of the shift register: the serial input bit and
// the parallel output word. clock/reset stay plain ports on the block.
//   serial_in : bit shifted into stage 0 at each rising clock edge
//   q         : parallel register contents, WIDTH bits
// Modports:
//   master : the producer of serial data / consumer of q
//   slave  : the shift register itself
interface shift_reg_4bit_if
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             serial_in;
  logic [WIDTH-1:0] q;

  modport master (output serial_in, input  q);
  modport slave  (input  serial_in, output q);

endinterface : shift_reg_4bit_if

// File: rtl/shift_reg_4bit.sv
// Serial-in, parallel-out shift register. Every rising edge of clock shifts
// serial_in into q[0] and moves each stage one place toward the MSB; the old
// MSB is discarded. There is no enable: the register shifts on every edge
// while reset is low. q is driven straight from flops.
// Parameters:
//   WIDTH       : number of stages, must be >= 2
//   RESET_VALUE : contents forced while reset is high
// Ports:
//   clock     : rising-edge clock
//   reset     : asynchronous, active-high reset
//   serial_in : input bit sampled at each rising edge
//   q         : parallel contents, q[WIDTH-1] oldest bit, q[0] newest
module shift_reg_4bit
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q
);

  // A one-stage register would make q[WIDTH-2:0] an empty slice.
  if (WIDTH < 2) begin : g_bad_width
    $error("shift_reg_4bit: WIDTH must be at least 2");
  end

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = {q_q[WIDTH-2:0], serial_in};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

  // Simulation-only checks; they have no effect on the synthesized logic.
  a_reset_value : assert property (@(posedge clock) reset |-> (q_q == RESET_VALUE))
    else $error("shift_reg_4bit: q differs from RESET_VALUE while reset is high");

  // Only checked across two consecutive out-of-reset edges; the first edge
  // after release has no valid previous shift to compare against.
  a_shift : assert property (@(posedge clock) disable iff (reset)
                             !$past(reset) |-> (q_q == {$past(q_q[WIDTH-2:0]), $past(serial_in)}))
    else $error("shift_reg_4bit: shift relation violated");

endmodule : shift_reg_4bit

// File: tb/tb_shift_reg_4bit.sv
module tb_shift_reg_4bit;
  import shift_reg_pkg::*;

  logic clock;
  logic reset;

  shift_reg_4bit_if #(.WIDTH(4)) sr4_if ();
  shift_reg_4bit_if #(.WIDTH(8)) sr8_if ();

  shift_reg_4bit #(.WIDTH(4)) dut4 (
    .clock     (clock),
    .reset     (reset),
    .serial_in (sr4_if.serial_in),
    .q         (sr4_if.q)
  );

  shift_reg_4bit #(.WIDTH(8)) dut8 (
    .clock     (clock),
    .reset     (reset),
    .serial_in (sr8_if.serial_in),
    .q         (sr8_if.q)
  );

  int n_chk = 0;
  int n_bad = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at a multiple of 10: drive the bit, let the edge at +5 happen,
  // sample at +8, then return at the next multiple of 10.
  task automatic shift4(input string tag, input logic si, input logic [3:0] exp);
    sr4_if.serial_in = si;
    #8;
    check_eq(tag, {28'd0, sr4_if.q}, {28'd0, exp});
    #2;
  endtask

  task automatic shift8(input string tag, input logic si, input logic [7:0] exp);
    sr8_if.serial_in = si;
    #8;
    check_eq(tag, {24'd0, sr8_if.q}, {24'd0, exp});
    #2;
  endtask

  logic [7:0] pat_in;
  logic [3:0] pat_exp [8];

  initial begin
    pat_in = 8'b0010_1101;  // bit i is the value driven on cycle i: 1,0,1,1,0,1,0,0
    pat_exp[0] = 4'b0001; pat_exp[1] = 4'b0010; pat_exp[2] = 4'b0101; pat_exp[3] = 4'b1011;
    pat_exp[4] = 4'b0110; pat_exp[5] = 4'b1101; pat_exp[6] = 4'b1010; pat_exp[7] = 4'b0100;

    // 1. reset
    reset = 1'b1;
    sr4_if.serial_in = 1'b1;
    sr8_if.serial_in = 1'b0;
    #1;
    check_eq("reset_immediate", {28'd0, sr4_if.q}, 32'd0);
    #5;  // t=6, after the edge at 5 with serial_in=1
    check_eq("reset_hold_edge5", {28'd0, sr4_if.q}, 32'd0);
    #4;  // t=10
    reset = 1'b0;

    // 2. pattern shift
    for (int i = 0; i < 8; i++) begin
      shift4($sformatf("pattern_%0d", i), pat_in[i], pat_exp[i]);
    end

    // 3. flush
    shift4("flush_0", 1'b0, 4'b1000);
    shift4("flush_1", 1'b0, 4'b0000);
    shift4("flush_2", 1'b0, 4'b0000);
    shift4("flush_3", 1'b0, 4'b0000);

    // 4. fill ones
    shift4("ones_0", 1'b1, 4'b0001);
    shift4("ones_1", 1'b1, 4'b0011);
    shift4("ones_2", 1'b1, 4'b0111);
    shift4("ones_3", 1'b1, 4'b1111);
    shift4("ones_4", 1'b1, 4'b1111);

    // 5. async reset mid-stream, starting from 1011
    shift4("pre_rst_0", 1'b1, 4'b1111);
    shift4("pre_rst_1", 1'b0, 4'b1110);
    shift4("pre_rst_2", 1'b1, 4'b1101);
    shift4("pre_rst_3", 1'b1, 4'b1011);
    // now 5 after the last edge, midway to the next one
    reset = 1'b1;
    sr4_if.serial_in = 1'b1;
    #1;
    check_eq("async_clear", {28'd0, sr4_if.q}, 32'd0);
    #7;  // edge passed at +5 with reset high
    check_eq("rst_hold_edge_a", {28'd0, sr4_if.q}, 32'd0);
    #10;
    check_eq("rst_hold_edge_b", {28'd0, sr4_if.q}, 32'd0);
    #2;  // multiple of 10
    reset = 1'b0;
    shift4("resume_0", 1'b1, 4'b0001);
    shift4("resume_1", 1'b0, 4'b0010);
    shift4("resume_2", 1'b1, 4'b0101);

    // 6. WIDTH=8 walking one
    reset = 1'b1;
    sr8_if.serial_in = 1'b0;
    #1;
    check_eq("w8_reset", {24'd0, sr8_if.q}, 32'd0);
    #9;
    reset = 1'b0;
    shift8("w8_walk_0", 1'b1, 8'h01);
    for (int k = 1; k < 8; k++) begin
      shift8($sformatf("w8_walk_%0d", k), 1'b0, 8'(1 << k));
    end
    shift8("w8_exit", 1'b0, 8'h00);
    shift8("w8_empty", 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule : tb_shift_reg_4bit
